// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic set (multiply-add and divider):
// FSM state encoding and the iteration-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1; called with WIDTH+1 so cnt can hold WIDTH.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_add_step.sv
// One shift-add iteration: conditional accumulate of the multiplicand, then shift
// multiplicand left and multiplier right. Purely combinational.
module mul_add_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mult,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mult_next
);

  always_comb begin
    acc_next   = mult[0] ? (acc + mcand) : acc;
    mcand_next = mcand << 1;
    mult_next  = mult >> 1;
  end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential unsigned multiply-accumulate: result = a*b + addend over WIDTH cycles.
// Optional SEQ_MUL_EARLY_DONE_EN ends RUN as soon as the remaining multiplier bits are zero.
module seq_mul_add
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   addend,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc, mcand, acc_next, mcand_next;
  logic [WIDTH-1:0]   mult, mult_next;
  logic [CW-1:0]      cnt;
  logic               last;

  mul_add_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mult       (mult),
    .acc_next   (acc_next),
    .mcand_next (mcand_next),
    .mult_next  (mult_next)
  );

`ifdef SEQ_MUL_EARLY_DONE_EN
  // Once the shifted multiplier is zero every later step adds nothing.
  assign last = (cnt == CW'(1)) || (mult_next == '0);
`else
  assign last = (cnt == CW'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = ST_RUN;
      end
      ST_RUN:  if (last) state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mult   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          acc   <= {{WIDTH{1'b0}}, addend};
          mcand <= {{WIDTH{1'b0}}, a};
          mult  <= b;
          cnt   <= CW'(WIDTH);
        end
        ST_RUN: begin
          acc   <= acc_next;
          mcand <= mcand_next;
          mult  <= mult_next;
          cnt   <= cnt - CW'(1);
          if (last) result <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule
